// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - shared TL-UL opcodes and register bridge state type
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/tl_ul_reg_bridge.sv
// rtl/tl_ul_reg_bridge.sv - single-beat TL-UL slave to valid/ready register bridge with timeout
module tl_ul_reg_bridge
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    output logic              auto_in_a_ready,
    input  logic              auto_in_a_valid,
    input  logic [2:0]        auto_in_a_bits_opcode,
    input  logic [ADDR_W-1:0] auto_in_a_bits_address,
    input  logic [DATA_W-1:0] auto_in_a_bits_data,
    input  logic              auto_in_d_ready,
    output logic              auto_in_d_valid,
    output logic [2:0]        auto_in_d_bits_opcode,
    output logic              auto_in_d_bits_denied,
    output logic [DATA_W-1:0] auto_in_d_bits_data,
    output logic              auto_in_d_bits_corrupt,
    output logic              reg_req_valid,
    input  logic              reg_req_ready,
    output logic              reg_req_write,
    output logic [ADDR_W-3:0] reg_req_addr,
    output logic [DATA_W-1:0] reg_req_wdata,
    input  logic              reg_resp_valid,
    input  logic [DATA_W-1:0] reg_resp_rdata,
    input  logic              reg_resp_err
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    bridge_state_e     state_q, state_d;
    logic [15:0]       timer_q;
    logic              drop_pend_q;
    logic              is_get_q;
    logic              denied_q;
    logic              write_q;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic a_fire, op_ok, timeout_hit, req_fire, unused_addr_lsb;

    assign a_fire          = (state_q == IDLE) && auto_in_a_valid;
    assign op_ok           = (auto_in_a_bits_opcode == PUT_FULL) || (auto_in_a_bits_opcode == GET);
    // >= rather than == so a request accepted on the last cycle still times out in WAIT
    assign timeout_hit     = timer_q >= TIMEOUT_LAST;
    assign req_fire        = (state_q == REQ) && !drop_pend_q && reg_req_ready;
    assign unused_addr_lsb = ^auto_in_a_bits_address[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (auto_in_a_valid) state_d = op_ok ? REQ : RESP;
            REQ: begin
                if (req_fire)         state_d = WAIT;
                else if (timeout_hit) state_d = RESP;
            end
            WAIT: if (reg_resp_valid || timeout_hit) state_d = RESP;
            RESP: if (auto_in_d_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        auto_in_a_ready = (state_q == IDLE);
        auto_in_d_valid = (state_q == RESP);
        reg_req_valid   = (state_q == REQ) && !drop_pend_q;
    end

    // A response still owed by a timed-out target must not be mistaken for the next one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q     <= '0;
            drop_pend_q <= 1'b0;
        end else begin
            if (a_fire) begin
                timer_q <= '0;
            end else if ((state_q == REQ) || (state_q == WAIT)) begin
                timer_q <= timer_q + 16'd1;
            end
            if ((state_q == WAIT) && !reg_resp_valid && timeout_hit) begin
                drop_pend_q <= 1'b1;
            end else if (reg_resp_valid && drop_pend_q) begin
                drop_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_get_q <= 1'b0;
            denied_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (a_fire) begin
                    is_get_q <= (auto_in_a_bits_opcode == GET);
                    write_q  <= (auto_in_a_bits_opcode == PUT_FULL);
                    denied_q <= !op_ok;
                    addr_q   <= auto_in_a_bits_address[ADDR_W-1:2];
                    wdata_q  <= auto_in_a_bits_data;
                    rdata_q  <= '0;
                end
                REQ: if (!req_fire && timeout_hit) begin
                    denied_q <= 1'b1;
                    rdata_q  <= '0;
                end
                WAIT: begin
                    if (reg_resp_valid) begin
                        denied_q <= reg_resp_err;
                        rdata_q  <= (is_get_q && !reg_resp_err) ? reg_resp_rdata : '0;
                    end else if (timeout_hit) begin
                        denied_q <= 1'b1;
                        rdata_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reg_req_write          = write_q;
    assign reg_req_addr           = addr_q;
    assign reg_req_wdata          = wdata_q;
    assign auto_in_d_bits_opcode  = is_get_q ? ACCESS_ACK_DATA : ACCESS_ACK;
    assign auto_in_d_bits_denied  = denied_q;
    assign auto_in_d_bits_data    = rdata_q;
    assign auto_in_d_bits_corrupt = denied_q & is_get_q;

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// tb/tb_tl_ul_reg_bridge.sv - directed bench with transaction-level model for tl_ul_reg_bridge
module tb_tl_ul_reg_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_ready, a_valid;
    logic [2:0]  a_op;
    logic [8:0]  a_addr;
    logic [31:0] a_data;
    logic        d_ready, d_valid;
    logic [2:0]  d_op;
    logic        d_denied, d_corrupt;
    logic [31:0] d_data;
    logic        req_valid, req_ready, req_write;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    tl_ul_reg_bridge #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clock                  (clk),
        .reset                  (rst),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_op),
        .auto_in_a_bits_address (a_addr),
        .auto_in_a_bits_data    (a_data),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_op),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt),
        .reg_req_valid          (req_valid),
        .reg_req_ready          (req_ready),
        .reg_req_write          (req_write),
        .reg_req_addr           (req_addr),
        .reg_req_wdata          (req_wdata),
        .reg_resp_valid         (resp_valid),
        .reg_resp_rdata         (resp_rdata),
        .reg_resp_err           (resp_err)
    );

    typedef struct {
        logic [2:0]  op;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_beat_t;

    typedef struct {
        logic        write;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } req_t;

    d_beat_t exp_d[$];
    req_t    exp_req[$];
    int      n_cmp = 0;
    int      n_err = 0;

    logic [2:0]  last_d_op;
    logic        last_d_denied, last_d_corrupt;
    logic [31:0] last_d_data;
    logic        last_req_write;
    logic [6:0]  last_req_addr;
    logic [31:0] last_req_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (d_valid) begin
                if (exp_d.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL d_unexpected: d_valid=1, expected no D beat at %0t", $time);
                end else begin
                    chk("d_opcode",  d_op,      exp_d[0].op);
                    chk("d_denied",  d_denied,  exp_d[0].denied);
                    chk("d_data",    d_data,    exp_d[0].data);
                    chk("d_corrupt", d_corrupt, exp_d[0].corrupt);
                    if (d_ready) begin
                        last_d_op      = d_op;
                        last_d_denied  = d_denied;
                        last_d_data    = d_data;
                        last_d_corrupt = d_corrupt;
                        void'(exp_d.pop_front());
                    end
                end
            end
            if (req_valid) begin
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: reg_req_valid=1, expected no request at %0t", $time);
                end else begin
                    chk("req_write", req_write, exp_req[0].write);
                    chk("req_addr",  req_addr,  exp_req[0].addr);
                    if (exp_req[0].write) chk("req_wdata", req_wdata, exp_req[0].wdata);
                    if (req_ready) begin
                        last_req_write = req_write;
                        last_req_addr  = req_addr;
                        last_req_wdata = req_wdata;
                        void'(exp_req.pop_front());
                    end
                end
            end
        end
    end

    // rdl: cycles the target holds off reg_req_ready; rsd: idle WAIT cycles before the response
    task automatic txn(input logic [2:0] op, input logic [8:0] addr, input logic [31:0] wd,
                       input int rdl, input int rsd, input logic [31:0] rd, input logic err,
                       input bit respond, input int dhold);
        bit      sup, is_get, req_to, wait_to;
        int      k;
        d_beat_t e;
        req_t    r;
        sup     = (op == 3'd0) || (op == 3'd4);
        is_get  = (op == 3'd4);
        req_to  = sup && (rdl + 1 > TO);
        wait_to = sup && !req_to && (!respond || (rdl + rsd + 2 > TO));
        e.op      = is_get ? 3'd1 : 3'd0;
        e.denied  = !sup || req_to || wait_to || err;
        e.data    = (is_get && !e.denied) ? rd : 32'd0;
        e.corrupt = e.denied && is_get;
        exp_d.push_back(e);
        if (sup) begin
            r.write = (op == 3'd0);
            r.addr  = addr[8:2];
            r.wdata = wd;
            exp_req.push_back(r);
        end
        a_valid = 1'b1; a_op = op; a_addr = addr; a_data = wd;
        @(negedge clk);
        chk("a_ready_idle", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        k = 0;
        if (sup) begin
            for (int c = 0; c <= rdl && k < TO; c++) begin
                req_ready = (c == rdl);
                k++;
                @(negedge clk);
                chk("req_valid_in_req", req_valid, 1'b1);
                step();
            end
            req_ready = 1'b0;
            if (req_to) begin
                void'(exp_req.pop_front());
            end else begin
                for (int c = 0; c <= rsd && k < TO; c++) begin
                    resp_valid = respond && (c == rsd);
                    resp_rdata = rd;
                    resp_err   = err;
                    k++;
                    @(negedge clk);
                    chk("req_low_in_wait", req_valid, 1'b0);
                    step();
                end
                resp_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("d_valid_latency", d_valid, 1'b1);
        for (int c = 0; c < dhold; c++) begin
            step();
            @(negedge clk);
            chk("a_ready_busy", a_ready, 1'b0);
            chk("d_valid_held", d_valid, 1'b1);
        end
        step();
        d_ready = 1'b1;
        @(negedge clk);
        step();
        d_ready = 1'b0;
        @(negedge clk);
        chk("a_ready_after_d", a_ready, 1'b1);
        chk("d_valid_after_d", d_valid, 1'b0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        d_beat_t e;
        req_t    r;
        a_valid = 0; a_op = 0; a_addr = 0; a_data = 0; d_ready = 0;
        req_ready = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0;

        @(negedge clk);
        chk("rst_a_ready",   a_ready,   1'b1);
        chk("rst_d_valid",   d_valid,   1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_write", req_write, 1'b0);
        chk("rst_d_denied",  d_denied,  1'b0);
        chk("rst_d_data",    d_data,    32'd0);
        step();
        rst = 1'b0;
        step();

        txn(3'd4, 9'h01C, 32'd0, 0, 1, 32'hDEADBEEF, 1'b0, 1'b1, 0);
        chk("t1_req_addr", last_req_addr, 7'h07);
        chk("t1_req_write", last_req_write, 1'b0);
        chk("t1_d_op", last_d_op, 3'd1);
        chk("t1_d_data", last_d_data, 32'hDEADBEEF);
        chk("t1_d_denied", last_d_denied, 1'b0);
        chk("t1_d_corrupt", last_d_corrupt, 1'b0);

        txn(3'd0, 9'h040, 32'h12345678, 1, 0, 32'hFFFFFFFF, 1'b1, 1'b1, 0);
        chk("t2_req_write", last_req_write, 1'b1);
        chk("t2_req_wdata", last_req_wdata, 32'h12345678);
        chk("t2_req_addr", last_req_addr, 7'h10);
        chk("t2_d_op", last_d_op, 3'd0);
        chk("t2_d_denied", last_d_denied, 1'b1);
        chk("t2_d_corrupt", last_d_corrupt, 1'b0);
        chk("t2_d_data", last_d_data, 32'd0);

        txn(3'd2, 9'h008, 32'h11111111, 0, 0, 32'd0, 1'b0, 1'b1, 0);
        chk("t3_d_denied", last_d_denied, 1'b1);
        chk("t3_d_op", last_d_op, 3'd0);

        txn(3'd4, 9'h00C, 32'd0, 0, 6, 32'hA5A5A5A5, 1'b0, 1'b1, 0);
        chk("edge_resp_wins_denied", last_d_denied, 1'b0);
        chk("edge_resp_wins_data", last_d_data, 32'hA5A5A5A5);

        txn(3'd0, 9'h010, 32'hCAFEF00D, 8, 0, 32'd0, 1'b0, 1'b1, 0);
        chk("req_timeout_denied", last_d_denied, 1'b1);

        txn(3'd4, 9'h020, 32'd0, 0, 100, 32'd0, 1'b0, 1'b0, 0);
        chk("t4_to_denied", last_d_denied, 1'b1);
        chk("t4_to_corrupt", last_d_corrupt, 1'b1);
        chk("t4_to_data", last_d_data, 32'd0);

        e.op = 3'd1; e.denied = 1'b0; e.data = 32'h5555AAAA; e.corrupt = 1'b0;
        exp_d.push_back(e);
        r.write = 1'b0; r.addr = 7'h09; r.wdata = 32'd0;
        exp_req.push_back(r);
        a_valid = 1'b1; a_op = 3'd4; a_addr = 9'h024; a_data = 32'd0;
        @(negedge clk);
        step();
        a_valid = 1'b0;
        @(negedge clk);
        chk("t4_drop_blocks_req", req_valid, 1'b0);
        step();
        resp_valid = 1'b1; resp_rdata = 32'hBAD0BAD0; resp_err = 1'b0;
        @(negedge clk);
        chk("t4_drop_blocks_req2", req_valid, 1'b0);
        step();
        resp_valid = 1'b0;
        req_ready  = 1'b1;
        @(negedge clk);
        chk("t4_late_resp_no_d", d_valid, 1'b0);
        chk("t4_req_after_drop", req_valid, 1'b1);
        step();
        req_ready  = 1'b0;
        resp_valid = 1'b1; resp_rdata = 32'h5555AAAA;
        @(negedge clk);
        chk("t4_d_not_yet", d_valid, 1'b0);
        step();
        resp_valid = 1'b0;
        @(negedge clk);
        chk("t4_d_valid", d_valid, 1'b1);
        step();
        d_ready = 1'b1;
        @(negedge clk);
        step();
        d_ready = 1'b0;
        chk("t4_next_get_data", last_d_data, 32'h5555AAAA);
        chk("t4_next_get_addr", last_req_addr, 7'h09);

        txn(3'd4, 9'h03C, 32'd0, 0, 0, 32'h0BADF00D, 1'b0, 1'b1, 10);
        chk("t5_d_data", last_d_data, 32'h0BADF00D);

        r.write = 1'b0; r.addr = 7'h0C; r.wdata = 32'd0;
        exp_req.push_back(r);
        a_valid = 1'b1; a_op = 3'd4; a_addr = 9'h030;
        @(negedge clk);
        step();
        a_valid   = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        step();
        req_ready = 1'b0;
        @(negedge clk);
        chk("t6_in_wait", req_valid, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_a_ready", a_ready, 1'b1);
        chk("t6_rst_d_valid", d_valid, 1'b0);
        chk("t6_rst_req_valid", req_valid, 1'b0);
        chk("t6_rst_req_addr", req_addr, 7'h00);
        chk("t6_rst_d_op", d_op, 3'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_no_d_after_rst", d_valid, 1'b0);
            chk("t6_idle_after_rst", a_ready, 1'b1);
        end
        chk("exp_d_drained", exp_d.size(), 32'd0);
        chk("exp_req_drained", exp_req.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
